// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/enable, M->E forwarding and dmem handshake for the F/E/M pipe.
// Define FWD_EN to forward M results into E; otherwise RAW hazards cost a one-cycle stall.
module pipeline_hazard_ctrl #(
    parameter int RW          = 5,
    parameter int TIMEOUT_CYC = 255,
    parameter int CW          = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [RW-1:0] rs1_e_i,
    input  logic [RW-1:0] rs2_e_i,
    input  logic [1:0]    rs_used_e_i,
    input  logic [RW-1:0] rd_m_i,
    input  logic          reg_wr_m_i,
    input  logic          load_m_i,
    input  logic          store_m_i,
    input  logic          br_taken_e_i,
    input  logic          dmem_ack_i,
    output logic          dmem_req_o,
    output logic          stall_f_o,
    output logic          flush_e_o,
    output logic          en_m_o,
    output logic          flush_m_o,
    output logic [1:0]    fwd_a_o,
    output logic [1:0]    fwd_b_o,
    output logic          dmem_err_o
);
    typedef enum logic {RUN, MEM_WAIT} state_t;
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYC);
    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          mem_m, in_wait, timeout, mem_stall, raw_stall, hit_a, hit_b;
    logic [1:0]    fwd_a, fwd_b;
    assign mem_m     = load_m_i | store_m_i;
    assign in_wait   = state == MEM_WAIT;
    assign timeout   = in_wait & !dmem_ack_i & (wait_cnt == TMO);
    assign mem_stall = in_wait ? !dmem_ack_i & !timeout : mem_m & !dmem_ack_i;
    assign hit_a     = rs_used_e_i[0] & reg_wr_m_i & (|rd_m_i) & (rd_m_i == rs1_e_i);
    assign hit_b     = rs_used_e_i[1] & reg_wr_m_i & (|rd_m_i) & (rd_m_i == rs2_e_i);
`ifdef FWD_EN
    // Load data only exists in the ack cycle, so a load hit forwards nothing before it.
    assign fwd_a     = !hit_a ? 2'b00 : !load_m_i ? 2'b01 : dmem_ack_i ? 2'b10 : 2'b00;
    assign fwd_b     = !hit_b ? 2'b00 : !load_m_i ? 2'b01 : dmem_ack_i ? 2'b10 : 2'b00;
    assign raw_stall = 1'b0;
`else
    assign fwd_a     = 2'b00;
    assign fwd_b     = 2'b00;
    assign raw_stall = (hit_a | hit_b) & !mem_stall;
`endif
    assign dmem_req_o = !rst_i & (in_wait | mem_m);
    assign stall_f_o  = !rst_i & (mem_stall | raw_stall);
    assign flush_e_o  = !rst_i & br_taken_e_i & !mem_stall & !raw_stall;
    assign en_m_o     = !rst_i & !mem_stall;
    assign flush_m_o  = !rst_i & raw_stall;
    assign fwd_a_o    = rst_i ? 2'b00 : fwd_a;
    assign fwd_b_o    = rst_i ? 2'b00 : fwd_b;
    assign dmem_err_o = !rst_i & timeout;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else if (state == RUN) begin
            if (mem_m && !dmem_ack_i) begin
                state    <= MEM_WAIT;
                wait_cnt <= CW'(1);
            end
        end else if (dmem_ack_i || timeout) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else if (wait_cnt != TMO) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks of stall/flush/forward/handshake outputs.
// Output vector order: req, stall_f, flush_e, en_m, flush_m, fwd_a, fwd_b, err.
module tb_pipeline_hazard_ctrl;
    logic       clk_i = 1'b0, rst_i = 1'b1;
    logic [4:0] rs1_e_i = '0, rs2_e_i = '0, rd_m_i = '0;
    logic [1:0] rs_used_e_i = '0;
    logic       reg_wr_m_i = 0, load_m_i = 0, store_m_i = 0, br_taken_e_i = 0, dmem_ack_i = 0;
    logic       dmem_req_o, stall_f_o, flush_e_o, en_m_o, flush_m_o, dmem_err_o;
    logic [1:0] fwd_a_o, fwd_b_o;
    logic [9:0] obs;
    int         total = 0, bad = 0;

    localparam logic [9:0] IDLE   = 10'b0_0_0_1_0_00_00_0;
    localparam logic [9:0] MSTALL = 10'b1_1_0_0_0_00_00_0;
    localparam logic [9:0] BR     = 10'b0_0_1_1_0_00_00_0;
    localparam logic [9:0] TMOUT  = 10'b1_0_0_1_0_00_00_1;
    localparam logic [9:0] RELBR  = 10'b1_0_1_1_0_00_00_0;
`ifdef FWD_EN
    localparam logic [9:0] HA    = 10'b0_0_0_1_0_01_00_0;
    localparam logic [9:0] HB    = 10'b0_0_0_1_0_00_01_0;
    localparam logic [9:0] BRHA  = 10'b0_0_1_1_0_01_00_0;
    localparam logic [9:0] LDACK = 10'b1_0_0_1_0_00_10_0;
    localparam logic [9:0] ZLAT  = 10'b1_0_0_1_0_10_00_0;
`else
    localparam logic [9:0] HA    = 10'b0_1_0_1_1_00_00_0;
    localparam logic [9:0] HB    = 10'b0_1_0_1_1_00_00_0;
    localparam logic [9:0] BRHA  = 10'b0_1_0_1_1_00_00_0;
    localparam logic [9:0] LDACK = 10'b1_1_0_1_1_00_00_0;
    localparam logic [9:0] ZLAT  = 10'b1_1_0_1_1_00_00_0;
`endif

    pipeline_hazard_ctrl #(.RW(5), .TIMEOUT_CYC(4), .CW(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .rs1_e_i(rs1_e_i), .rs2_e_i(rs2_e_i),
        .rs_used_e_i(rs_used_e_i), .rd_m_i(rd_m_i), .reg_wr_m_i(reg_wr_m_i),
        .load_m_i(load_m_i), .store_m_i(store_m_i), .br_taken_e_i(br_taken_e_i),
        .dmem_ack_i(dmem_ack_i), .dmem_req_o(dmem_req_o), .stall_f_o(stall_f_o),
        .flush_e_o(flush_e_o), .en_m_o(en_m_o), .flush_m_o(flush_m_o),
        .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .dmem_err_o(dmem_err_o)
    );

    always #5 clk_i = ~clk_i;
    assign obs = {dmem_req_o, stall_f_o, flush_e_o, en_m_o, flush_m_o, fwd_a_o, fwd_b_o, dmem_err_o};

    task automatic chk(input string tag, input logic [9:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge; outputs are sampled 1ns later.
    task automatic set(input logic [4:0] rd, input logic wr, ld, st,
                       input logic [4:0] r1, r2, input logic [1:0] used, input logic br, ack);
        @(negedge clk_i);
        rd_m_i = rd; reg_wr_m_i = wr; load_m_i = ld; store_m_i = st;
        rs1_e_i = r1; rs2_e_i = r2; rs_used_e_i = used; br_taken_e_i = br; dmem_ack_i = ack;
        #1;
    endtask

    initial begin
        #3 chk("reset", 10'b0);
        @(negedge clk_i) rst_i = 1'b0;
        set(0, 0, 0, 0, 0, 0, 2'b00, 0, 0); chk("idle", IDLE);
        set(5, 1, 0, 0, 5, 0, 2'b01, 0, 0); chk("hit_a", HA);
        set(0, 0, 0, 0, 5, 0, 2'b01, 0, 0); chk("hit_a_after", IDLE);
        set(0, 1, 0, 0, 0, 0, 2'b11, 0, 0); chk("x0_no_hit", IDLE);
        set(6, 1, 0, 0, 6, 6, 2'b00, 0, 0); chk("unused_no_hit", IDLE);
        set(7, 1, 0, 0, 1, 7, 2'b10, 0, 0); chk("hit_b", HB);
        set(7, 0, 0, 0, 7, 7, 2'b11, 0, 0); chk("no_wr_no_hit", IDLE);
        set(0, 0, 0, 0, 0, 0, 2'b00, 1, 0); chk("branch", BR);
        set(5, 1, 0, 0, 5, 0, 2'b01, 1, 0); chk("branch_hit", BRHA);
        // load waits 3 cycles, acked on the 4th
        set(9, 1, 1, 0, 0, 9, 2'b10, 0, 0); chk("ld_c0", MSTALL);
        set(9, 1, 1, 0, 0, 9, 2'b10, 0, 0); chk("ld_c1", MSTALL);
        set(9, 1, 1, 0, 0, 9, 2'b10, 0, 0); chk("ld_c2", MSTALL);
        set(9, 1, 1, 0, 0, 9, 2'b10, 0, 1); chk("ld_ack", LDACK);
        set(0, 0, 0, 0, 0, 0, 2'b00, 0, 0); chk("ld_back_run", IDLE);
        set(3, 1, 1, 0, 3, 0, 2'b01, 0, 1); chk("ld_zero_lat", ZLAT);
        set(0, 0, 0, 0, 0, 0, 2'b00, 0, 0); chk("zl_stays_run", IDLE);
        // store with no ack runs into the watchdog
        set(0, 0, 0, 1, 0, 0, 2'b00, 0, 0); chk("st_c0", MSTALL);
        set(0, 0, 0, 1, 0, 0, 2'b00, 0, 0); chk("st_c1", MSTALL);
        set(0, 0, 0, 1, 0, 0, 2'b00, 0, 0); chk("st_c2", MSTALL);
        set(0, 0, 0, 1, 0, 0, 2'b00, 0, 0); chk("st_c3", MSTALL);
        set(0, 0, 0, 1, 0, 0, 2'b00, 0, 0); chk("st_timeout", TMOUT);
        set(0, 0, 0, 0, 0, 0, 2'b00, 0, 0); chk("st_back_run", IDLE);
        // branch held in E across a memory wait
        set(0, 0, 0, 1, 0, 0, 2'b00, 1, 0); chk("br_wait_c0", MSTALL);
        set(0, 0, 0, 1, 0, 0, 2'b00, 1, 0); chk("br_wait_c1", MSTALL);
        set(0, 0, 0, 1, 0, 0, 2'b00, 1, 1); chk("br_release", RELBR);
        set(0, 0, 0, 0, 0, 0, 2'b00, 0, 0); chk("br_back_run", IDLE);
        // reset during the second MEM_WAIT cycle
        set(0, 0, 0, 1, 0, 0, 2'b00, 0, 0); chk("rst_c0", MSTALL);
        set(0, 0, 0, 1, 0, 0, 2'b00, 0, 0); chk("rst_c1", MSTALL);
        set(0, 0, 0, 1, 0, 0, 2'b00, 0, 0); chk("rst_c2", MSTALL);
        #2 rst_i = 1'b1;
        #1 chk("rst_async", 10'b0);
        store_m_i = 1'b0;
        @(negedge clk_i) rst_i = 1'b0;
        #1 chk("rst_release", IDLE);
        set(0, 1, 0, 0, 0, 0, 2'b01, 0, 0); chk("rst_x0", IDLE);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
